sobel_window_buffer: RTL and testbench
======================================

SOBEL_WINDOW_BUFFER -- requirements
Module: sobel_window_buffer

Interface
REQ-001 Parameter IMG_WIDTH, default 640, pixels per line (>=3).
REQ-002 Parameter IMG_HEIGHT, default 480, lines per frame (>=3).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 n_rst  input  1  reset, asynchronous, active-low.
REQ-005 frame_start  input  1  marks the pixel presented this cycle as row 0, col 0.
REQ-006 pixel_valid  input  1  pixel_in valid this cycle; module always accepts, no backpressure.
REQ-007 pixel_in  input  8  grayscale pixel, raster order.
REQ-008 windowBuffer  output  9x8  3x3 window, row-major: [0] top-left, [4] centre, [8] bottom-right (newest pixel).
REQ-009 start_calculations  output  1  one-cycle strobe; windowBuffer holds a complete valid window.
REQ-010 frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.
REQ-011 frame_err  output  1  sticky protocol error flag (present only under SOBEL_WIN_ERR_EN).

Function
REQ-012 The module SHALL keep the two previous lines in two line buffers of IMG_WIDTH bytes each, plus a 3x3 register window.
REQ-013 On each accepted pixel, the three window columns SHALL shift left; the new right column is {line_buf1 out, line_buf0 out, pixel_in} top to bottom.
REQ-014 Column counter col SHALL increment per accepted pixel, wrap IMG_WIDTH-1 -> 0 and then increment row.
REQ-015 start_calculations SHALL assert exactly one clock after accepting a pixel with row>=2 and col>=2; otherwise low.
REQ-016 Windows spanning a line wrap (col 0,1) SHALL NOT be flagged; (IMG_WIDTH-2)*(IMG_HEIGHT-2) strobes per frame.
REQ-017 With pixel_valid low, window, counters and line buffers SHALL hold; start_calculations low.
REQ-018 FSM states: IDLE (waiting for frame_start), FILL (row<2), RUN (row>=2), DONE (one cycle).
REQ-019 IDLE->FILL on frame_start&&pixel_valid; FILL->RUN on accepting last pixel of row 1; RUN->DONE on accepting pixel (IMG_WIDTH-1, IMG_HEIGHT-1); DONE->IDLE unconditionally, or ->FILL if frame_start&&pixel_valid that cycle.
REQ-020 frame_done SHALL be high exactly in DONE.
REQ-021 frame_start&&pixel_valid in FILL or RUN SHALL abort the frame: counters restart with that pixel at (0,0), no strobe for it.
REQ-022 Pixels with pixel_valid in IDLE without frame_start SHALL be discarded.
REQ-023 frame_start without pixel_valid SHALL be ignored.

Reset
REQ-024 On n_rst low: state IDLE, col=row=0, windowBuffer all 0, start_calculations=0, frame_done=0, frame_err=0, asynchronously.
REQ-025 Line buffer contents need not be cleared; no strobe SHALL depend on stale contents.
REQ-026 Reset asserted mid-frame SHALL discard the frame; next frame starts only on frame_start.

Configuration
REQ-027 Macro SOBEL_WIN_ERR_EN defined: frame_err port exists, set by REQ-021 abort or REQ-022 discard, cleared only by reset.
REQ-028 Macro undefined: frame_err port and its logic absent; all other behaviour identical.

Structure
REQ-029 Package sobel_pkg SHALL hold pixel_t (8-bit), window_t (9 x pixel_t), the FSM state enum, and default IMG_WIDTH/IMG_HEIGHT constants.
REQ-030 Sub-module sobel_line_buffer (IMG_WIDTH-deep byte delay line, shift-enable) SHALL be instantiated twice.

Verification (bench uses IMG_WIDTH=4, IMG_HEIGHT=4, pixels 0..15 raster)
REQ-031 Continuous frame -> strobes one cycle after pixels 10,11,14,15; first window {0,1,2,4,5,6,8,9,10}, last {5,6,7,9,10,11,13,14,15}; frame_done one cycle after pixel 15.
REQ-032 pixel_valid low every other cycle -> same four windows, strobes shifted accordingly, window held during gaps.
REQ-033 frame_start reasserted at pixel 6 -> restart; next strobe after 11th pixel of new frame; frame_err=1 under SOBEL_WIN_ERR_EN.
REQ-034 n_rst pulsed after pixel 9 -> outputs zero immediately; pixels without frame_start produce no strobe.
REQ-035 Back-to-back frames, frame_start in DONE cycle -> second frame yields four strobes with correct windows, no missed pixel.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared types for the Sobel 3x3 window buffer: pixel/window types, FSM states
// and default image geometry.
package sobel_pkg;

    localparam int DEF_IMG_WIDTH  = 640;
    localparam int DEF_IMG_HEIGHT = 480;

    typedef logic [7:0] pixel_t;
    typedef pixel_t [8:0] window_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_RUN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/sobel_line_buffer.sv
// DEPTH-byte delay line: dout is the byte pushed DEPTH enabled shifts ago.
// Contents are not reset; the window logic never flags a window built from stale data.
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int DEPTH = DEF_IMG_WIDTH
) (
    input  logic       clk,
    input  logic       en,
    input  logic [7:0] din,
    output logic [7:0] dout
);

    logic [DEPTH-1:0][7:0] sr;

    always_ff @(posedge clk) begin
        if (en) sr <= {sr[DEPTH-2:0], din};
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/sobel_window_buffer.sv
// 3x3 sliding window over a raster pixel stream for a Sobel filter.
// Optional sticky protocol-error flag frame_err is built when SOBEL_WIN_ERR_EN is defined.
module sobel_window_buffer
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            frame_start,
    input  logic            pixel_valid,
    input  logic [7:0]      pixel_in,
    output logic [8:0][7:0] windowBuffer,
    output logic            start_calculations,
    output logic            frame_done
`ifdef SOBEL_WIN_ERR_EN
    ,
    output logic            frame_err
`endif
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    state_t        state, state_nxt;
    logic [CW-1:0] col, col_nxt, cur_col;
    logic [RW-1:0] row, row_nxt, cur_row;
    logic          restart, accept, last_col, stb_nxt;
    pixel_t        lb0_out, lb1_out;
    window_t       win;

    always_comb begin
        restart   = pixel_valid && frame_start;
        accept    = restart || (pixel_valid && (state == ST_FILL || state == ST_RUN));
        // a restarting pixel is always treated as (0,0), whatever the counters held
        cur_col   = restart ? '0 : col;
        cur_row   = restart ? '0 : row;
        last_col  = (cur_col == CW'(IMG_WIDTH - 1));
        col_nxt   = col;
        row_nxt   = row;
        stb_nxt   = accept && !restart && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
        state_nxt = state;
        if (accept) begin
            if (last_col) begin
                col_nxt = '0;
                row_nxt = cur_row + RW'(1);
            end else begin
                col_nxt = cur_col + CW'(1);
                row_nxt = cur_row;
            end
        end
        case (state)
            ST_IDLE: if (restart) state_nxt = ST_FILL;
            ST_FILL: begin
                if (restart) state_nxt = ST_FILL;
                else if (accept && last_col && cur_row == RW'(1)) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (restart) state_nxt = ST_FILL;
                else if (accept && last_col && cur_row == RW'(IMG_HEIGHT - 1)) begin
                    state_nxt = ST_DONE;
                    row_nxt   = '0;
                end
            end
            ST_DONE: state_nxt = restart ? ST_FILL : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    sobel_line_buffer #(.DEPTH(IMG_WIDTH)) u_line_buf0 (
        .clk  (clk),
        .en   (accept),
        .din  (pixel_in),
        .dout (lb0_out)
    );

    sobel_line_buffer #(.DEPTH(IMG_WIDTH)) u_line_buf1 (
        .clk  (clk),
        .en   (accept),
        .din  (lb0_out),
        .dout (lb1_out)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state              <= ST_IDLE;
            col                <= '0;
            row                <= '0;
            win                <= '0;
            start_calculations <= 1'b0;
        end else begin
            state              <= state_nxt;
            col                <= col_nxt;
            row                <= row_nxt;
            start_calculations <= stb_nxt;
            if (accept) begin
                win[0] <= win[1];
                win[1] <= win[2];
                win[2] <= lb1_out;
                win[3] <= win[4];
                win[4] <= win[5];
                win[5] <= lb0_out;
                win[6] <= win[7];
                win[7] <= win[8];
                win[8] <= pixel_in;
            end
        end
    end

    assign windowBuffer = win;
    assign frame_done   = (state == ST_DONE);

`ifdef SOBEL_WIN_ERR_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) frame_err <= 1'b0;
        else if ((restart && (state == ST_FILL || state == ST_RUN)) ||
                 (pixel_valid && !frame_start && state == ST_IDLE))
            frame_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_sobel_window_buffer.sv
// Directed bench for sobel_window_buffer on a 4x4 image (pixel value = base + raster index).
module tb_sobel_window_buffer;

    logic            clk = 1'b0;
    logic            n_rst = 1'b0;
    logic            frame_start = 1'b0;
    logic            pixel_valid = 1'b0;
    logic [7:0]      pixel_in = '0;
    logic [8:0][7:0] win;
    logic            stb;
    logic            done;
`ifdef SOBEL_WIN_ERR_EN
    logic            err;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    sobel_window_buffer #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .frame_start        (frame_start),
        .pixel_valid        (pixel_valid),
        .pixel_in           (pixel_in),
        .windowBuffer       (win),
        .start_calculations (stb),
        .frame_done         (done)
`ifdef SOBEL_WIN_ERR_EN
        ,
        .frame_err          (err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [71:0] exp_win(input int base, input int k);
        logic [71:0] w;
        int r, c;
        r = k / 4;
        c = k % 4;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[(i*3+j)*8 +: 8] = 8'(base + (r - 2 + i) * 4 + (c - 2 + j));
        return w;
    endfunction

    // drive one cycle, then check the registered outputs just after the edge
    task automatic send(input bit fs, input bit v, input int px, input bit e_stb,
                        input bit e_done, input bit chkw, input logic [71:0] ew);
        frame_start = fs;
        pixel_valid = v;
        pixel_in    = 8'(px);
        @(posedge clk);
        #1;
        chk("strobe", 72'(stb), 72'(e_stb));
        chk("frame_done", 72'(done), 72'(e_done));
        if (chkw) chk("window", win, ew);
    endtask

    task automatic idle();
        send(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic frame(input int base, input bit gap);
        bit s;
        for (int k = 0; k < 16; k++) begin
            s = (k / 4 >= 2) && (k % 4 >= 2);
            send(k == 0, 1'b1, base + k, s, k == 15, s, exp_win(base, k));
            if (gap) send(1'b0, 1'b0, 0, 1'b0, 1'b0, s, exp_win(base, k));
        end
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_window", win, '0);
        chk("rst_strobe", 72'(stb), 72'(0));
        chk("rst_done", 72'(done), 72'(0));
`ifdef SOBEL_WIN_ERR_EN
        chk("rst_err", 72'(err), 72'(0));
`endif
        n_rst = 1'b1;
        idle();

        // continuous frame, with explicit first/last window constants
        for (int k = 0; k < 16; k++) begin
            send(k == 0, 1'b1, k, (k == 10 || k == 11 || k == 14 || k == 15), k == 15, 1'b0, '0);
            if (k == 10) chk("first_win", win, {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0});
            if (k == 15) chk("last_win", win, {8'd15, 8'd14, 8'd13, 8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5});
        end
        idle();

        // pixel_valid low every other cycle
        frame(20, 1'b1);
        idle();
`ifdef SOBEL_WIN_ERR_EN
        chk("err_clean", 72'(err), 72'(0));
`endif

        // abort at pixel 6, new frame restarts there
        for (int k = 0; k < 6; k++) send(k == 0, 1'b1, k, 1'b0, 1'b0, 1'b0, '0);
        frame(100, 1'b0);
        idle();
`ifdef SOBEL_WIN_ERR_EN
        chk("err_abort", 72'(err), 72'(1));
`endif

        // reset mid-frame after pixel 9
        for (int k = 0; k < 10; k++) send(k == 0, 1'b1, k, 1'b0, 1'b0, 1'b0, '0);
        n_rst = 1'b0;
        #2;
        chk("async_rst_window", win, '0);
        chk("async_rst_strobe", 72'(stb), 72'(0));
        chk("async_rst_done", 72'(done), 72'(0));
`ifdef SOBEL_WIN_ERR_EN
        chk("async_rst_err", 72'(err), 72'(0));
`endif
        #2;
        n_rst = 1'b1;
        for (int k = 10; k < 16; k++) send(1'b0, 1'b1, k, 1'b0, 1'b0, 1'b1, '0);
        idle();

        // back-to-back frames, second frame_start lands in the DONE cycle
        frame(0, 1'b0);
        frame(50, 1'b0);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
